// File: rtl/bram32.sv
// Simple dual-port block RAM: write-only port A with byte lanes, read-only
// port B with a registered, read-first output. Shaped for BRAM inference.
module bram32 #(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 10,
  parameter int    DEPTH      = 1 << ADDR_WIDTH,
  parameter string INIT_FILE  = ""
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   w_addr,
  input  logic [DATA_WIDTH-1:0]   w_dat,
  input  logic                    w_enb,
  input  logic [DATA_WIDTH/8-1:0] byte_enb,
  input  logic [ADDR_WIDTH-1:0]   r_addr,
  input  logic                    r_enb,
  output logic [DATA_WIDTH-1:0]   r_dat
);
  localparam int NUM_LANES = DATA_WIDTH / 8;

  logic [NUM_LANES-1:0][7:0] mem [DEPTH];
  logic [NUM_LANES-1:0][7:0] w_lanes;

  assign w_lanes = w_dat;

  always_ff @(posedge clk) begin
    if (rst && w_enb) begin
      for (int i = 0; i < NUM_LANES; i++)
        if (byte_enb[i]) mem[w_addr][i] <= w_lanes[i];
    end
  end

  // Separate output register: reading mem here with <= yields the old word
  // when the same address is written on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_dat <= '0;
    else if (r_enb) r_dat <= mem[r_addr];
  end
endmodule

// File: tb/tb_bram32.sv
// Randomised and directed checks of bram32 against a word-array model.
module tb_bram32;
  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  w_addr;
  logic [31:0] w_dat;
  logic        w_enb;
  logic [3:0]  byte_enb;
  logic [9:0]  r_addr;
  logic        r_enb;
  logic [31:0] r_dat;

  bram32 dut (
    .clk(clk), .rst(rst), .w_addr(w_addr), .w_dat(w_dat), .w_enb(w_enb),
    .byte_enb(byte_enb), .r_addr(r_addr), .r_enb(r_enb), .r_dat(r_dat)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem [1024];
  logic [31:0] exp_r;

  // Advance one edge: the model captures the read before applying the write.
  task automatic tick();
    logic [31:0] old;
    if (rst && r_enb) exp_r = ref_mem[r_addr];
    if (rst && w_enb) begin
      old = ref_mem[w_addr];
      for (int i = 0; i < 4; i++)
        if (byte_enb[i]) old[8*i +: 8] = w_dat[8*i +: 8];
      ref_mem[w_addr] = old;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_enb = 1'b0; r_enb = 1'b0; byte_enb = 4'h0;
  endtask

  task automatic test_reset();
    rst = 1'b0; idle(); w_addr = '0; w_dat = '0; r_addr = '0;
    exp_r = '0;
    tick(); tick();
    total++;
    if (r_dat !== 32'h0) begin bad++; $display("FAIL reset_hold got=%h want=%h", r_dat, 32'h0); end
    rst = 1'b1;
    tick(); tick();
    total++;
    if (r_dat !== 32'h0) begin bad++; $display("FAIL reset_release got=%h want=%h", r_dat, 32'h0); end
  endtask

  task automatic test_load();
    logic [31:0] prog [4];
    prog[0] = 32'h00500093; prog[1] = 32'h00300113;
    prog[2] = 32'h002081B3; prog[3] = 32'h00000073;
    for (int i = 0; i < 4; i++) begin
      w_enb = 1'b1; byte_enb = 4'hF; w_addr = 10'(i); w_dat = prog[i];
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      r_enb = 1'b1; r_addr = 10'(i);
      tick();
      total++;
      if (r_dat !== prog[i] || exp_r !== prog[i]) begin
        bad++; $display("FAIL load_read addr=%0d got=%h want=%h", i, r_dat, prog[i]);
      end
    end
    idle();
  endtask

  task automatic test_byte_lanes();
    w_enb = 1'b1; byte_enb = 4'hF; w_addr = 10'd5; w_dat = 32'hFFFFFFFF; tick();
    byte_enb = 4'b0101; w_dat = 32'h12345678; tick();
    idle(); r_enb = 1'b1; r_addr = 10'd5; tick();
    total++;
    if (r_dat !== 32'hFF34FF78) begin bad++; $display("FAIL byte_lanes got=%h want=%h", r_dat, 32'hFF34FF78); end
    // all-lanes-off write must leave the word alone
    idle(); w_enb = 1'b1; byte_enb = 4'h0; w_addr = 10'd5; w_dat = 32'h0; tick();
    idle(); r_enb = 1'b1; r_addr = 10'd5; tick();
    total++;
    if (r_dat !== 32'hFF34FF78) begin bad++; $display("FAIL byte_enb_zero got=%h want=%h", r_dat, 32'hFF34FF78); end
    idle();
  endtask

  task automatic test_rdw();
    w_enb = 1'b1; byte_enb = 4'hF; w_addr = 10'd7; w_dat = 32'hAAAA0000; tick();
    w_dat = 32'h5555FFFF; r_enb = 1'b1; r_addr = 10'd7; tick();
    total++;
    if (r_dat !== 32'hAAAA0000) begin bad++; $display("FAIL rdw_old got=%h want=%h", r_dat, 32'hAAAA0000); end
    w_enb = 1'b0; tick();
    total++;
    if (r_dat !== 32'h5555FFFF) begin bad++; $display("FAIL rdw_new got=%h want=%h", r_dat, 32'h5555FFFF); end
    idle();
  endtask

  task automatic test_boundary();
    w_enb = 1'b1; byte_enb = 4'hF; w_addr = 10'h3FF; w_dat = 32'hDEADBEEF; tick();
    idle(); r_enb = 1'b1; r_addr = 10'h3FF; tick();
    total++;
    if (r_dat !== 32'hDEADBEEF) begin bad++; $display("FAIL boundary_read got=%h want=%h", r_dat, 32'hDEADBEEF); end
    r_enb = 1'b0; r_addr = 10'd1; tick(); tick();
    total++;
    if (r_dat !== 32'hDEADBEEF) begin bad++; $display("FAIL hold got=%h want=%h", r_dat, 32'hDEADBEEF); end
    idle();
  endtask

  // Random traffic on a small address window so collisions are frequent.
  task automatic test_random();
    for (int a = 16; a < 32; a++) begin
      w_enb = 1'b1; byte_enb = 4'hF; w_addr = 10'(a); w_dat = $urandom; tick();
    end
    idle();
    for (int n = 0; n < 300; n++) begin
      w_enb    = 1'($urandom_range(0, 1));
      byte_enb = 4'($urandom);
      w_addr   = 10'($urandom_range(16, 31));
      w_dat    = $urandom;
      r_enb    = ($urandom_range(0, 3) != 0);
      r_addr   = 10'($urandom_range(16, 31));
      tick();
      total++;
      if (r_dat !== exp_r) begin
        bad++; $display("FAIL random n=%0d got=%h want=%h", n, r_dat, exp_r);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    r_enb = 1'b1; r_addr = 10'd1; tick();
    total++;
    if (r_dat !== 32'h00300113) begin bad++; $display("FAIL pre_reset_read got=%h want=%h", r_dat, 32'h00300113); end
    #2 rst = 1'b0;
    #1;
    total++;
    if (r_dat !== 32'h0) begin bad++; $display("FAIL async_reset got=%h want=%h", r_dat, 32'h0); end
    exp_r = '0;
    // write during reset must be dropped
    w_enb = 1'b1; byte_enb = 4'hF; w_addr = 10'd0; w_dat = 32'hBAD0BAD0; tick();
    total++;
    if (r_dat !== 32'h0) begin bad++; $display("FAIL reset_read_ignored got=%h want=%h", r_dat, 32'h0); end
    rst = 1'b1; idle(); r_enb = 1'b1; r_addr = 10'd0; tick();
    total++;
    if (r_dat !== 32'h00500093) begin bad++; $display("FAIL mem_kept got=%h want=%h", r_dat, 32'h00500093); end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    test_reset();
    test_load();
    test_byte_lanes();
    test_rdw();
    test_boundary();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
